// File: rtl/nanov_mmio.sv
// Memory-mapped GPIO and UART-transmit peripheral block for the nanov CPU.
// The UART transmitter is built only when NANOV_MMIO_UART_EN is defined.
module nanov_mmio #(
   parameter int CLKS_PER_BIT = 16,
   parameter int GPIO_W       = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [31:0]       data_in,
   input  logic              store_addr_in,
   input  logic              store_data_in,
   output logic [31:0]       ext_data_out,
   output logic [GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic              uart_tx
);

   localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

   logic [31:0]       addr_q;
   logic [31:0]       wdata;
   logic              periph;
   logic [3:0]        reg_idx;
   logic              wr_en;
   logic              busy;
   logic [GPIO_W-1:0] gpio_meta;
   logic [GPIO_W-1:0] gpio_sync;
   logic [31:0]       rd_data;

   assign periph  = |addr_q[31:24];
   assign reg_idx = addr_q[5:2];
   // addr_q is the pre-edge value, so a same-cycle address strobe cannot retarget this write
   assign wr_en   = store_data_in && periph;

   // The CPU presents store data bit-reversed on its data_out bus
   always_comb begin
      wdata = '0;
      for (int i = 0; i < 32; i++) wdata[i] = data_in[31-i];
   end

   always_ff @(posedge clk) begin
      if (!rstn) addr_q <= '0;
      else if (store_addr_in) addr_q <= data_in;
   end

   always_ff @(posedge clk) begin
      if (!rstn) gpio_out <= '0;
      else if (wr_en && reg_idx == 4'h0) gpio_out <= wdata[GPIO_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         gpio_meta <= '0;
         gpio_sync <= '0;
      end else begin
         gpio_meta <= gpio_in;
         gpio_sync <= gpio_meta;
      end
   end

   always_comb begin
      rd_data = '0;
      if (periph) begin
         case (reg_idx)
            4'h0:    rd_data = 32'(gpio_out);
            4'h1:    rd_data = 32'(gpio_sync);
            4'h5:    rd_data = {31'b0, busy};
            default: rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) ext_data_out <= '0;
      else ext_data_out <= rd_data;
   end

`ifdef NANOV_MMIO_UART_EN
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   uart_state_t state, state_nxt;
   logic [15:0] baud_cnt, baud_nxt;
   logic [2:0]  bit_idx, bit_nxt;
   logic [7:0]  shift, shift_nxt;
   logic        tx_nxt;
   logic        uart_start;
   logic        unused_bits;

   assign uart_start  = wr_en && reg_idx == 4'h4;
   assign busy        = state != IDLE;
   assign unused_bits = ^{addr_q[23:6], addr_q[1:0], wdata};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         uart_tx  <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         uart_tx  <= tx_nxt;
      end
   end

   always_ff @(posedge clk) shift <= shift_nxt;

   // uart_tx is registered: each state drives the level for the following bit period
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      tx_nxt    = uart_tx;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (uart_start) begin
               state_nxt = START;
               baud_nxt  = BAUD_RELOAD;
               shift_nxt = wdata[7:0];
               tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (baud_cnt == 16'd0) begin
               state_nxt = DATA;
               baud_nxt  = BAUD_RELOAD;
               bit_nxt   = 3'd0;
               tx_nxt    = shift[0];
            end else begin
               baud_nxt = baud_cnt - 16'd1;
            end
         end
         DATA: begin
            if (baud_cnt == 16'd0) begin
               baud_nxt = BAUD_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_nxt   = bit_idx + 3'd1;
                  shift_nxt = {1'b0, shift[7:1]};
                  tx_nxt    = shift[1];
               end
            end else begin
               baud_nxt = baud_cnt - 16'd1;
            end
         end
         STOP: begin
            if (baud_cnt == 16'd0) begin
               state_nxt = IDLE;
               tx_nxt    = 1'b1;
            end else begin
               baud_nxt = baud_cnt - 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
`else
   logic unused_bits;

   assign uart_tx     = 1'b1;
   assign busy        = 1'b0;
   assign unused_bits = ^{addr_q[23:6], addr_q[1:0], wdata, BAUD_RELOAD};
`endif

endmodule

// File: tb/tb_nanov_mmio.sv
// Scoreboard bench for nanov_mmio: stimulus queues expected values per cycle,
// a negedge monitor compares them against the DUT outputs.
module tb_nanov_mmio;

   localparam int CPB    = 4;
   localparam int GPIO_W = 8;
   localparam int K_EXT  = 0;
   localparam int K_GPIO = 1;
   localparam int K_TX   = 2;

   logic              clk = 1'b0;
   logic              rstn;
   logic [31:0]       data_in;
   logic              store_addr_in;
   logic              store_data_in;
   logic [31:0]       ext_data_out;
   logic [GPIO_W-1:0] gpio_out;
   logic [GPIO_W-1:0] gpio_in;
   logic              uart_tx;

   nanov_mmio #(.CLKS_PER_BIT(CPB), .GPIO_W(GPIO_W)) dut (
      .clk(clk), .rstn(rstn), .data_in(data_in),
      .store_addr_in(store_addr_in), .store_data_in(store_data_in),
      .ext_data_out(ext_data_out), .gpio_out(gpio_out), .gpio_in(gpio_in),
      .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void exp_at(input int c, input int k, input logic [31:0] v, input string n);
      exp_t e;
      e.cyc = c; e.kind = k; e.val = v; e.name = n;
      q.push_back(e);
   endfunction

   // Monitor: compare every queued expectation that falls due on this cycle
   always @(negedge clk) begin
      int i;
      logic [31:0] act;
      i = 0;
      while (i < q.size()) begin
         if (q[i].cyc == cyc) begin
            case (q[i].kind)
               K_EXT:   act = ext_data_out;
               K_GPIO:  act = 32'(gpio_out);
               default: act = {31'b0, uart_tx};
            endcase
            vectors++;
            if (act !== q[i].val) begin
               miscompares++;
               $display("FAIL %s @cyc %0d: got %h, want %h", q[i].name, cyc, act, q[i].val);
            end
            q.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic addr_strobe(input logic [31:0] a);
      data_in = a; store_addr_in = 1'b1;
      step();
      store_addr_in = 1'b0;
   endtask

   task automatic data_strobe(input logic [31:0] d);
      data_in = d; store_data_in = 1'b1;
      step();
      store_data_in = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] byte1;
      rstn = 1'b0; data_in = '0; store_addr_in = 1'b0; store_data_in = 1'b0; gpio_in = '0;
      step();
      // strobes during reset must be ignored
      n = cyc;
      exp_at(n + 3, K_GPIO, 32'h0, "rst_gpio");
      exp_at(n + 3, K_EXT,  32'h0, "rst_ext");
      exp_at(n + 3, K_TX,   32'h1, "rst_tx");
      addr_strobe(32'h1000_0000);
      data_strobe(32'hFF00_0000);
      step();
      step();
      rstn = 1'b1;
      step();

      n = cyc;
      exp_at(n + 2, K_GPIO, 32'h5A, "gpio_wr_5a");
      exp_at(n + 3, K_EXT,  32'h5A, "rd_gpio_5a");
      addr_strobe(32'h1000_0000);
      data_strobe(32'h5A00_0000);
      step(); step();
      vectors++;
      if (gpio_out !== 8'h5A) begin
         miscompares++;
         $display("FAIL direct_gpio_5a: got %h, want 5a", gpio_out);
      end

      // bit reversal and ignored address bits [23:6]
      n = cyc;
      exp_at(n + 2, K_GPIO, 32'h01, "gpio_bitrev");
      exp_at(n + 3, K_EXT,  32'h01, "rd_gpio_01");
      addr_strobe(32'h01FF_FFC0);
      data_strobe(32'h8000_00FF);
      step(); step();
      vectors++;
      if (gpio_out !== 8'h01) begin
         miscompares++;
         $display("FAIL direct_gpio_bitrev: got %h, want 01", gpio_out);
      end

      n = cyc;
      exp_at(n + 2, K_EXT,  32'h0,  "rd_nonperiph");
      exp_at(n + 2, K_GPIO, 32'h01, "nonperiph_wr_a");
      exp_at(n + 3, K_GPIO, 32'h01, "nonperiph_wr_b");
      addr_strobe(32'h0000_0400);
      data_strobe(32'hFF00_0000);
      step();

      n = cyc;
      exp_at(n + 2, K_GPIO, 32'h01, "idx2_wr_ignored");
      exp_at(n + 2, K_EXT,  32'h0,  "rd_idx2");
      addr_strobe(32'h1000_0008);
      data_strobe(32'hFF00_0000);
      step();

      n = cyc;
      gpio_in = 8'hC3;
      exp_at(n + 2, K_EXT, 32'h0,  "sync_not_early");
      exp_at(n + 3, K_EXT, 32'hC3, "rd_gpio_in_c3");
      addr_strobe(32'h1000_0004);
      step(); step(); step();
      n = cyc;
      gpio_in = 8'h3C;
      exp_at(n + 2, K_EXT, 32'hC3, "sync_hold_c3");
      exp_at(n + 3, K_EXT, 32'h3C, "rd_gpio_in_3c");
      step(); step(); step();

      n = cyc;
      exp_at(n + 2, K_EXT, 32'h0, "rd_idx3");
      addr_strobe(32'h1000_000C);
      step();
      n = cyc;
      exp_at(n + 2, K_EXT, 32'h0, "rd_nonperiph_idx1");
      addr_strobe(32'h0000_0004);
      step();

      // both strobes together: the write uses the previous (periph, idx 0) address
      addr_strobe(32'h1000_0000);
      step();
      n = cyc;
      exp_at(n + 1, K_GPIO, 32'h00, "same_cycle_wr");
      exp_at(n + 2, K_EXT,  32'h0,  "same_cycle_rd");
      data_in = 32'h0000_0001; store_addr_in = 1'b1; store_data_in = 1'b1;
      step();
      store_addr_in = 1'b0; store_data_in = 1'b0;
      step(); step();

      n = cyc;
      exp_at(n + 2, K_GPIO, 32'hA5, "gpio_wr_a5");
      addr_strobe(32'h1000_0000);
      data_strobe(32'hA500_0000);
      step();

`ifdef NANOV_MMIO_UART_EN
      // frame of 0x41 with busy read back through index 5
      n = cyc;
      byte1 = 8'h41;
      exp_at(n + 1, K_TX, 32'h1, "tx_idle_pre");
      for (int i = 0; i < 40; i++) begin
         if (i < 4) exp_at(n + 2 + i, K_TX, 32'h0, "tx_start");
         else if (i < 36) exp_at(n + 2 + i, K_TX, {31'b0, byte1[(i - 4) / 4]}, "tx_data");
         else exp_at(n + 2 + i, K_TX, 32'h1, "tx_stop");
      end
      for (int i = 42; i < 46; i++) exp_at(n + i, K_TX, 32'h1, "tx_idle_post");
      exp_at(n + 4,  K_EXT, 32'h1, "busy_start");
      exp_at(n + 20, K_EXT, 32'h1, "busy_data");
      exp_at(n + 42, K_EXT, 32'h1, "busy_stop");
      exp_at(n + 43, K_EXT, 32'h0, "busy_clear");
      addr_strobe(32'h1000_0010);
      data_strobe(32'h8200_0000);
      addr_strobe(32'h1000_0014);
      while (cyc < n + 46) step();

      // frame of 0x07: dropped second write, then reset during data bit 3
      n = cyc;
      for (int i = 2; i < 6; i++)   exp_at(n + i, K_TX, 32'h0, "tx2_start");
      for (int i = 6; i < 18; i++)  exp_at(n + i, K_TX, 32'h1, "tx2_bits012");
      for (int i = 18; i < 20; i++) exp_at(n + i, K_TX, 32'h0, "tx2_bit3");
      for (int i = 20; i < 50; i++) exp_at(n + i, K_TX, 32'h1, "tx_after_rst");
      exp_at(n + 20, K_GPIO, 32'h0, "gpio_after_rst");
      exp_at(n + 20, K_EXT,  32'h0, "ext_after_rst");
      addr_strobe(32'h1000_0010);
      data_strobe(32'hE000_0000);
      while (cyc < n + 10) step();
      data_strobe(32'h0000_0000);
      while (cyc < n + 19) step();
      rstn = 1'b0;
      step(); step();
      rstn = 1'b1;
      exp_at(cyc + 2, K_EXT, 32'h0, "busy_after_rst");
      addr_strobe(32'h1000_0014);
      while (cyc < n + 50) step();
`else
      n = cyc;
      for (int i = 1; i < 21; i++) exp_at(n + i, K_TX, 32'h1, "tx_disabled");
      exp_at(n + 4, K_EXT,  32'h0,  "rd_idx5_disabled");
      exp_at(n + 5, K_GPIO, 32'hA5, "gpio_kept");
      addr_strobe(32'h1000_0010);
      data_strobe(32'h8200_0000);
      addr_strobe(32'h1000_0014);
      while (cyc < n + 21) step();
`endif

      // reset with strobes asserted clears gpio_out and the read register
      addr_strobe(32'h1000_0000);
      data_strobe(32'h3300_0000);
      step();
      n = cyc;
      exp_at(n + 1, K_GPIO, 32'h0, "rst2_gpio");
      exp_at(n + 1, K_EXT,  32'h0, "rst2_ext");
      exp_at(n + 1, K_TX,   32'h1, "rst2_tx");
      exp_at(n + 4, K_EXT,  32'h0, "rst2_addr_cleared");
      rstn = 1'b0;
      data_in = 32'hFF00_0000; store_addr_in = 1'b1; store_data_in = 1'b1;
      step();
      store_addr_in = 1'b0; store_data_in = 1'b0;
      step();
      rstn = 1'b1;

      for (int i = 0; i < 100 && q.size() > 0; i++) step();
      vectors++;
      if (gpio_out !== 8'h00) begin
         miscompares++;
         $display("FAIL direct_gpio_after_rst2: got %h, want 00", gpio_out);
      end
      vectors++;
      if (uart_tx !== 1'b1) begin
         miscompares++;
         $display("FAIL direct_tx_after_rst2: got %b, want 1", uart_tx);
      end
      foreach (q[i]) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: expectation for cyc %0d never checked", q[i].name, q[i].cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nanov_mmio.md
NANOV_MMIO -- requirements
Module: nanov_mmio

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL provide parameter GPIO_W, default 8: width of the GPIO output and GPIO input ports.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port data_in  input  32  CPU data_out bus: an address when store_addr_in is high, bit-reversed store data when store_data_in is high.
REQ-006 SHALL have port store_addr_in  input  1  one-cycle strobe from the CPU: data_in holds a load/store address.
REQ-007 SHALL have port store_data_in  input  1  one-cycle strobe from the CPU: data_in holds bit-reversed store data.
REQ-008 SHALL have port ext_data_out  output  32  registered read data; drives the CPU ext_data_in bus.
REQ-009 SHALL have port gpio_out  output  GPIO_W  GPIO output register.
REQ-010 SHALL have port gpio_in  input  GPIO_W  asynchronous GPIO inputs.
REQ-011 SHALL have port uart_tx  output  1  UART transmit line, 8N1 framing, idle high.

Function
REQ-012 SHALL capture addr_q <= data_in on every cycle where store_addr_in=1, for both loads and stores.
REQ-013 SHALL decode periph = (addr_q[31:24] != 0) and reg index = addr_q[5:2]; addr_q[23:6] and addr_q[1:0] are ignored.
REQ-014 SHALL form wdata as the bit reversal of data_in, wdata[i] = data_in[31-i], on every cycle where store_data_in=1.
REQ-015 SHALL perform a write only when store_data_in=1 and periph=1; a write to a non-peripheral address has no effect.
REQ-016 SHALL use the addr_q value from before the clock edge when store_addr_in and store_data_in are both high in the same cycle.
REQ-017 SHALL write gpio_out <= wdata[GPIO_W-1:0] on a write to index 0x0.
REQ-018 SHALL start a UART frame with byte wdata[7:0] on a write to index 0x4 if the UART is idle; a write while busy SHALL be dropped.
REQ-019 SHALL ignore writes to every other index.
REQ-020 SHALL synchronise gpio_in through two flops to form gpio_sync.
REQ-021 SHALL register ext_data_out every cycle from addr_q; value is zero-extended to 32 bits: index 0x0 -> gpio_out; 0x1 -> gpio_sync; 0x5 -> {31'b0, busy}; any other index, or periph=0 -> 0.
REQ-022 SHALL make ext_data_out reflect a new address 2 cycles after its store_addr_in strobe, and hold it stable while addr_q is unchanged, apart from gpio_sync and busy updates.
REQ-023 SHALL implement the UART FSM with states IDLE, START, DATA, STOP and a baud counter that counts down from CLKS_PER_BIT-1.
REQ-024 SHALL, on a start write, move IDLE->START on the next edge with uart_tx=0 for CLKS_PER_BIT cycles.
REQ-025 SHALL in DATA send bits 0..7, LSB first, each for CLKS_PER_BIT cycles.
REQ-026 SHALL in STOP drive uart_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-027 SHALL assert busy=1 in every state except IDLE; a new write is accepted in the first cycle back in IDLE.

Reset
REQ-028 SHALL, while rstn=0, set addr_q=0, ext_data_out=0, gpio_out=0, both gpio_sync stages=0, UART state IDLE, uart_tx=1, busy=0, baud counter=0 and bit index=0.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame, drive uart_tx=1 on the next edge, and discard the byte.
REQ-030 SHALL ignore strobes sampled in any cycle where rstn=0.

Configuration
REQ-031 SHALL, with NANOV_MMIO_UART_EN defined, include the UART FSM and behave as specified in REQ-018 and REQ-023 to REQ-027.
REQ-032 SHALL, with NANOV_MMIO_UART_EN undefined, omit the UART logic entirely: uart_tx tied to 1, writes to index 0x4 ignored, index 0x5 reads 0.

Verification
REQ-033 SHALL cover: store_addr_in with data_in=0x10000000, then store_data_in with data_in=0x5A000000 -> gpio_out=0x5A on the next edge.
REQ-034 SHALL cover: store_addr_in with 0x00000400, then store_data_in with 0xFF000000 -> gpio_out unchanged; ext_data_out=0 two cycles after the address strobe.
REQ-035 SHALL cover: gpio_in=0xC3, then store_addr_in with 0x10000004 -> ext_data_out=0x000000C3 within 3 cycles.
REQ-036 SHALL cover: CLKS_PER_BIT=4, write 0x82000000 to 0x10000010, i.e. byte 0x41 -> uart_tx 0 (4 cyc), then 1,0,0,0,0,0,1,0 (4 cyc each), then 1 (4 cyc); index 0x5 reads 1 throughout the frame, then 0.
REQ-037 SHALL cover: second UART write during a frame -> dropped; rstn=0 at data bit 3 -> uart_tx=1 next edge; busy=0; gpio_out=0.
REQ-038 SHALL cover: build without NANOV_MMIO_UART_EN, write to 0x10000010 -> uart_tx stays 1; index 0x5 reads 0.
